// File: rtl/sram_line_controller.sv
// sram_line_controller
// Bridges the MEM stage / data cache to a narrow external SRAM. A CPU word is
// split into SRAM_DW-wide beats, and every beat is stretched by WAIT_CYCLES
// wait states. A store is written through to the SRAM and then the enclosing
// line is read back. A load miss only reads the line. The finished line is
// handed to the cache with a one-cycle cache_write strobe. The pipeline is
// frozen while ready is low.
module sram_line_controller #(
  parameter int DATA_W      = 32,
  parameter int SRAM_DW     = 16,
  parameter int SRAM_AW     = 18,
  parameter int LINE_WORDS  = 2,
  parameter int WAIT_CYCLES = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         mem_w_en,
  input  logic                         mem_r_en,
  input  logic                         hit,
  input  logic [SRAM_AW-1:0]           addr_in,
  input  logic [DATA_W-1:0]            st_value,
  inout  wire  [SRAM_DW-1:0]           sram_data,
  output logic [SRAM_AW-1:0]           sram_addr,
  output logic                         sram_we_n,
  output logic [LINE_WORDS*DATA_W-1:0] line_data,
  output logic                         cache_write,
  output logic                         ready
);

  // Beat geometry. The counter widths never drop below one bit, so that
  // degenerate parameter sets still elaborate.
  localparam int BEATS      = DATA_W / SRAM_DW;
  localparam int LINE_BEATS = LINE_WORDS * BEATS;
  localparam int BW         = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int LB_BITS    = (LINE_BEATS > 1) ? $clog2(LINE_BEATS) : 1;
  localparam int WC_BITS    = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

  // Alignment masks. One mask clears the halfword-within-word bits. The other
  // clears the halfword-within-line bits.
  localparam logic [SRAM_AW-1:0] WA_MASK = ~SRAM_AW'(BEATS - 1);
  localparam logic [SRAM_AW-1:0] LB_MASK = ~SRAM_AW'(LINE_BEATS - 1);

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    FILL,
    CWRITE,
    DONE
  } state_t;

  state_t state;
  state_t next_state;

  logic [SRAM_AW-1:0] wa;
  logic [SRAM_AW-1:0] lb;
  logic [DATA_W-1:0]  st_latched;
  logic [WC_BITS-1:0] wait_cnt;
  logic [LB_BITS-1:0] beat_cnt;
  logic [BW-1:0]      write_beat;
  logic               beat_end;
  logic               last_write_beat;
  logic               last_fill_beat;
  logic               drive_en;
  logic [SRAM_DW-1:0] drive_val;

  // The beat-progress flags are shared by the next-state logic and the
  // datapath.
  assign beat_end        = (wait_cnt == WC_BITS'(WAIT_CYCLES));
  assign last_write_beat = (beat_cnt == LB_BITS'(BEATS - 1));
  assign last_fill_beat  = (beat_cnt == LB_BITS'(LINE_BEATS - 1));
  assign write_beat      = beat_cnt[BW-1:0];

  // State register. Reset aborts any access and returns to IDLE.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic. A store takes priority over a load miss, and a store
  // always falls through into the line fill.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (mem_w_en) begin
          next_state = WRITE;
        end else if (mem_r_en && !hit) begin
          next_state = FILL;
        end
      end
      WRITE: begin
        if (beat_end && last_write_beat) begin
          next_state = FILL;
        end
      end
      FILL: begin
        if (beat_end && last_fill_beat) begin
          next_state = CWRITE;
        end
      end
      CWRITE:  next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Wait and beat counters. They restart on every state change, so that WRITE
  // and FILL both begin at beat 0 with a fresh wait count.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wait_cnt <= '0;
      beat_cnt <= '0;
    end else if (next_state != state) begin
      wait_cnt <= '0;
      beat_cnt <= '0;
    end else if (state == WRITE || state == FILL) begin
      if (beat_end) begin
        wait_cnt <= '0;
        beat_cnt <= beat_cnt + LB_BITS'(1);
      end else begin
        wait_cnt <= wait_cnt + WC_BITS'(1);
      end
    end
  end

  // Request capture when leaving IDLE. After this point, later changes on
  // addr_in or st_value cannot disturb the access in flight.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wa         <= '0;
      lb         <= '0;
      st_latched <= '0;
    end else if (state == IDLE && next_state != IDLE) begin
      wa         <= addr_in & WA_MASK;
      lb         <= addr_in & LB_MASK;
      st_latched <= st_value;
    end
  end

  // Line assembly. Each fill beat's halfword is sampled on the edge that
  // closes the beat's final wait cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      line_data <= '0;
    end else if (state == FILL && beat_end) begin
      for (int k = 0; k < LINE_BEATS; k++) begin
        if (beat_cnt == LB_BITS'(k)) begin
          line_data[k*SRAM_DW +: SRAM_DW] <= sram_data;
        end
      end
    end
  end

  // Output decode. This covers the SRAM address, write strobe, bus drive,
  // cache strobe and ready handshake. ready is held low throughout reset.
  always_comb begin
    sram_addr   = '0;
    sram_we_n   = 1'b1;
    drive_en    = 1'b0;
    drive_val   = '0;
    cache_write = 1'b0;
    ready       = 1'b0;
    case (state)
      IDLE: begin
        ready = rst & ~mem_w_en & ~(mem_r_en & ~hit);
      end
      WRITE: begin
        sram_addr = wa + {{(SRAM_AW-LB_BITS){1'b0}}, beat_cnt};
        sram_we_n = 1'b0;
        drive_en  = 1'b1;
        for (int i = 0; i < BEATS; i++) begin
          if (write_beat == BW'(i)) begin
            drive_val = st_latched[i*SRAM_DW +: SRAM_DW];
          end
        end
      end
      FILL: begin
        sram_addr = lb + {{(SRAM_AW-LB_BITS){1'b0}}, beat_cnt};
      end
      CWRITE: begin
        cache_write = 1'b1;
      end
      DONE: begin
        ready = rst;
      end
      default: begin
        ready = 1'b0;
      end
    endcase
  end

  assign sram_data = drive_en ? drive_val : {SRAM_DW{1'bz}};

endmodule
